// File: rtl/paralelo_serial_pkg.sv
// Shared definitions for the parallel-to-serial framer: FSM encoding and the
// default idle pattern.
package paralelo_serial_pkg;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } ps_state_e;

  localparam logic [7:0] IDLE_DEFAULT = 8'hBC;

endpackage

// File: rtl/paralelo_serial_param_if.sv
// Word-in / bit-out bus of the framer. master = word producer and stream
// observer, slave = the framer itself.
interface paralelo_serial_param_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready;
  logic              serial_out;
  logic              frame_start;
  logic              active;

  modport master (
    output data_in, valid_in,
    input  ready, serial_out, frame_start, active
  );

  modport slave (
    input  data_in, valid_in,
    output ready, serial_out, frame_start, active
  );
endinterface

// File: rtl/ps_bit_counter.sv
// Frame bit counter: counts 0..FRAME_W-1 and flags the last bit, whose
// closing edge reloads the shift register.
module ps_bit_counter #(
  parameter  int FRAME_W = 8,
  localparam int CNT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1
) (
  input  logic             clk,
  input  logic             reset_L,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             load
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

  assign load = (bit_cnt == LAST);

  // Reset parks on the last bit so the first edge after release is a load.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)  bit_cnt <= LAST;
    else if (load) bit_cnt <= '0;
    else           bit_cnt <= bit_cnt + 1'b1;
  end
endmodule

// File: rtl/paralelo_serial_param.sv
// Parallel-to-serial framer, MSB first, with SYNC idle preamble after reset.
// Build option: define PARALELO_SERIAL_PARITY_EN to append an even-parity bit.
module paralelo_serial_param
  import paralelo_serial_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] IDLE_WORD  = DATA_W'(IDLE_DEFAULT),
  parameter int                SYNC_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    reset_L,
  paralelo_serial_param_if.slave  bus
);
`ifdef PARALELO_SERIAL_PARITY_EN
  localparam int FRAME_W = DATA_W + 1;
`else
  localparam int FRAME_W = DATA_W;
`endif
  localparam int CNT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [7:0] SYNC_LAST = 8'(SYNC_WORDS - 1);

  logic [CNT_W-1:0]   bit_cnt;
  logic               load;
  logic [FRAME_W-1:0] sreg;
  logic [7:0]         sync_cnt;
  ps_state_e          state;

  function automatic logic [FRAME_W-1:0] build_frame(input logic [DATA_W-1:0] w);
`ifdef PARALELO_SERIAL_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  ps_bit_counter #(.FRAME_W(FRAME_W)) u_cnt (
    .clk     (clk),
    .reset_L (reset_L),
    .bit_cnt (bit_cnt),
    .load    (load)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sreg     <= '0;
      sync_cnt <= '0;
      state    <= SYNC;
    end else if (load) begin
      case (state)
        SYNC: begin
          sreg     <= build_frame(IDLE_WORD);
          sync_cnt <= sync_cnt + 8'd1;
          if (sync_cnt == SYNC_LAST) state <= RUN;
        end
        RUN: begin
          // No backpressure: an absent word becomes an idle frame.
          sreg <= bus.valid_in ? build_frame(bus.data_in) : build_frame(IDLE_WORD);
        end
        default: state <= SYNC;
      endcase
    end else begin
      sreg <= {sreg[FRAME_W-2:0], 1'b0};
    end
  end

  // All outputs decode flops only; reset parks bit_cnt off zero.
  assign bus.serial_out  = sreg[FRAME_W-1];
  assign bus.frame_start = (bit_cnt == '0);
  assign bus.ready       = (state == RUN) && load;
  assign bus.active      = (state == RUN);
endmodule

// File: tb/tb_paralelo_serial_param.sv
// Scoreboard bench for paralelo_serial_param (DATA_W=8, SYNC_WORDS=4, idle BC).
module tb_paralelo_serial_param;
`ifdef PARALELO_SERIAL_PARITY_EN
  localparam int FW = 9;
`else
  localparam int FW = 8;
`endif
  localparam logic [7:0] IDLE = 8'hBC;

  typedef struct packed {
    logic so;
    logic fs;
    logic rdy;
    logic act;
  } exp_t;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  paralelo_serial_param_if #(.DATA_W(8)) bus ();

  paralelo_serial_param #(
    .DATA_W(8), .IDLE_WORD(8'hBC), .SYNC_WORDS(4)
  ) dut (
    .clk(clk), .reset_L(reset_L), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mk_frame(input logic [7:0] w);
`ifdef PARALELO_SERIAL_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  task automatic push_frame(input logic [7:0] w, input bit act);
    logic [FW-1:0] f;
    f = mk_frame(w);
    for (int i = 0; i < FW; i++)
      q.push_back('{so: f[FW-1-i], fs: (i == 0), rdy: (act && i == FW-1), act: act});
  endtask

  task automatic test_reset;
    bus.data_in = 8'h00;
    bus.valid_in = 1'b0;
    reset_L = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus.serial_out, bus.frame_start, bus.ready, bus.active} !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset cyc %0d: got so/fs/rdy/act=%b required 0000", i,
                 {bus.serial_out, bus.frame_start, bus.ready, bus.active});
      end
    end
  endtask

  task automatic test_sync(input string tag);
    exp_t e;
    reset_L = 1'b1;
    for (int k = 0; k < 4; k++) push_frame(IDLE, k == 3);
    for (int i = 0; i < 4*FW; i++) begin
      @(negedge clk);
      e = q.pop_front();
      vectors++;
      if ({bus.serial_out, bus.frame_start, bus.ready, bus.active} !== e) begin
        miscompares++;
        $display("FAIL %s cyc %0d: got so/fs/rdy/act=%b required %b", tag, i,
                 {bus.serial_out, bus.frame_start, bus.ready, bus.active}, e);
      end
    end
  endtask

  task automatic test_data;
    logic [7:0] words [3] = '{8'hFF, 8'h55, 8'h00};
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      bus.data_in = words[k];
      bus.valid_in = 1'b1;
      push_frame(words[k], 1'b1);
      for (int i = 0; i < FW; i++) begin
        @(negedge clk);
        e = q.pop_front();
        vectors++;
        if ({bus.serial_out, bus.frame_start, bus.ready, bus.active} !== e) begin
          miscompares++;
          $display("FAIL data w%0d bit %0d: got so/fs/rdy/act=%b required %b", k, i,
                   {bus.serial_out, bus.frame_start, bus.ready, bus.active}, e);
        end
      end
    end
    bus.valid_in = 1'b0;
  endtask

  task automatic test_invalid;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      bus.data_in = (k == 0) ? 8'hFF : 8'h55;
      bus.valid_in = (k == 1);
      push_frame((k == 0) ? IDLE : 8'h55, 1'b1);
      for (int i = 0; i < FW; i++) begin
        @(negedge clk);
        e = q.pop_front();
        vectors++;
        if ({bus.serial_out, bus.frame_start, bus.ready, bus.active} !== e) begin
          miscompares++;
          $display("FAIL invalid f%0d bit %0d: got so/fs/rdy/act=%b required %b", k, i,
                   {bus.serial_out, bus.frame_start, bus.ready, bus.active}, e);
        end
      end
    end
    bus.valid_in = 1'b0;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic [7:0] w;
    bit v;
    for (int k = 0; k < 8; k++) begin
      w = 8'($urandom_range(0, 255));
      v = ($urandom_range(0, 3) != 0);
      bus.data_in = w;
      bus.valid_in = v;
      push_frame(v ? w : IDLE, 1'b1);
      for (int i = 0; i < FW; i++) begin
        @(negedge clk);
        e = q.pop_front();
        vectors++;
        if ({bus.serial_out, bus.frame_start, bus.ready, bus.active} !== e) begin
          miscompares++;
          $display("FAIL b2b w=%h v=%0d bit %0d: got so/fs/rdy/act=%b required %b", w, v, i,
                   {bus.serial_out, bus.frame_start, bus.ready, bus.active}, e);
        end
      end
    end
    bus.valid_in = 1'b0;
  endtask

  task automatic test_midframe_reset;
    exp_t e;
    bus.data_in = 8'hFF;
    bus.valid_in = 1'b1;
    push_frame(8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = q.pop_front();
      vectors++;
      if ({bus.serial_out, bus.frame_start, bus.ready, bus.active} !== e) begin
        miscompares++;
        $display("FAIL abort bit %0d: got so/fs/rdy/act=%b required %b", i,
                 {bus.serial_out, bus.frame_start, bus.ready, bus.active}, e);
      end
    end
    bus.valid_in = 1'b0;
    @(posedge clk);
    #2 reset_L = 1'b0;
    #1;
    vectors++;
    if ({bus.serial_out, bus.frame_start, bus.ready, bus.active} !== 4'b0000) begin
      miscompares++;
      $display("FAIL abort async: got so/fs/rdy/act=%b required 0000",
               {bus.serial_out, bus.frame_start, bus.ready, bus.active});
    end
    q.delete();
    @(negedge clk);
    test_sync("resync");
  endtask

  initial begin
    bus.data_in = 8'h00;
    bus.valid_in = 1'b0;
    test_reset();
    test_sync("sync");
    test_data();
    test_invalid();
    test_back_to_back();
    test_midframe_reset();
    test_data();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
